wb_axi_bridge_arbiter: RTL and testbench
========================================

// Module: wb_axi_bridge_arbiter
// PURPOSE
//  Shares one Wishbone-to-AXI4-Lite bridge slave port among NUM_MASTERS Wishbone masters.
//  Round-robin arbitration, one transaction in flight, per-grant optional timeout with error return.
//  Sits between the CPU/DMA Wishbone masters and the bridge's wb_stb/we/adr/dat/ack port.
// PARAMETERS
//  NUM_MASTERS  4   number of requesting masters (2..8)
//  DATA_WIDTH   32  Wishbone data width
//  ADDR_WIDTH   32  Wishbone address width
//  TIMEOUT      0   cycles in BUSY without wb_ack_i before error; 0 = disabled
// PORTS
//  wb_clk_i     in   1                       clock
//  wb_rst_ni    in   1                       async active-low reset
//  m_stb_i      in   NUM_MASTERS             per-master strobe (request)
//  m_we_i       in   NUM_MASTERS             per-master write enable
//  m_adr_i      in   NUM_MASTERS*ADDR_WIDTH  per-master address, master i at [i*AW +: AW]
//  m_dat_i      in   NUM_MASTERS*DATA_WIDTH  per-master write data
//  m_dat_o      out  DATA_WIDTH              read data, shared by all masters, valid with m_ack_o
//  m_ack_o      out  NUM_MASTERS             per-master ack, one-hot or zero
//  m_err_o      out  NUM_MASTERS             per-master timeout error, one-hot or zero
//  wb_stb_o     out  1                       strobe to bridge
//  wb_we_o      out  1                       write enable to bridge
//  wb_adr_o     out  ADDR_WIDTH              address to bridge
//  wb_dat_o     out  DATA_WIDTH              write data to bridge
//  wb_dat_i     in   DATA_WIDTH              read data from bridge
//  wb_ack_i     in   1                       ack from bridge
//  grant_o      out  NUM_MASTERS             current grant, one-hot or zero (debug)
//  stray_ack_o  out  1                       sticky: wb_ack_i seen outside BUSY
// BEHAVIOUR
//  Reset (wb_rst_ni=0, async): state=IDLE; all outputs 0; RR pointer = master 0 highest priority.
//  States: IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: if any m_stb_i, pick first requester at/after RR pointer (wrap NUM_MASTERS-1 -> 0);
//   register grant, m_we_i/m_adr_i/m_dat_i of winner into wb_*_o; wb_stb_o=1 next cycle; -> BUSY.
//   Arbitration latency: request seen in cycle k -> wb_stb_o high in cycle k+1.
//  BUSY: wb_stb_o/we/adr/dat held constant from latched copy; master-side changes ignored.
//   wb_ack_i=1: m_ack_o[grant]=1 combinationally same cycle, m_dat_o=wb_dat_i;
//   wb_stb_o=0 next cycle; RR pointer = grant+1 (mod N); -> RELEASE.
//   Timeout counter clears on entry; if TIMEOUT>0 and counter reaches TIMEOUT-1 with no ack:
//   m_err_o[grant]=1 for one cycle, no m_ack_o, wb_stb_o=0 next cycle, pointer advances, -> RELEASE.
//   wb_ack_i and timeout in same cycle: ack wins, no error.
//  RELEASE: one cycle, wb_stb_o=0, grant_o=0, no arbitration; lets grantee drop strobe. -> IDLE.
//  Granted master dropping m_stb_i before ack: transaction still completes, ack still pulsed.
//  wb_ack_i in IDLE/RELEASE: discarded (no m_ack_o), sets stray_ack_o until reset.
//  m_dat_o = wb_dat_i at all times; meaningful only with m_ack_o.
//  Back-to-back from one master: minimum 3-cycle spacing between strobes (IDLE,BUSY,RELEASE).
//  Reset mid-BUSY: wb_stb_o drops immediately; no ack/err issued to the grantee.
// TESTING
//  1 Single write: m0 stb,we=1,adr=0x1000,dat=0xDEADBEEF; bridge ack after 3 cycles
//    -> wb_adr_o=0x1000, wb_dat_o=0xDEADBEEF, m_ack_o=4'b0001 same cycle as wb_ack_i.
//  2 Read: m2 stb,we=0,adr=0x2004; bridge ack, wb_dat_i=0xCAFEF00D -> m_ack_o=4'b0100, m_dat_o=0xCAFEF00D.
//  3 Round-robin: m0..m3 all request continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
//  4 Timeout: TIMEOUT=16, bridge never acks -> m_err_o[grant] pulse 16 cycles after BUSY entry,
//    wb_stb_o=0 next cycle; ack on cycle 16 instead -> ack, no error.
//  5 Stray ack: wb_ack_i pulse in IDLE -> no m_ack_o, stray_ack_o=1 held until reset.
//  6 Async reset mid-BUSY (m1 granted) -> wb_stb_o, grant_o, m_ack_o go 0 without clock edge;
//    after release, m0 and m1 requesting -> m0 granted first.

Source files
------------

// File: rtl/wb_axi_bridge_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the bridge slave port.
// The arbiter connects via the slave modport; the environment uses the master modport.
interface wb_axi_bridge_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [DATA_WIDTH-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic                              wb_stb_o;
    logic                              wb_we_o;
    logic [ADDR_WIDTH-1:0]             wb_adr_o;
    logic [DATA_WIDTH-1:0]             wb_dat_o;
    logic [DATA_WIDTH-1:0]             wb_dat_i;
    logic                              wb_ack_i;
    logic [NUM_MASTERS-1:0]            grant_o;
    logic                              stray_ack_o;

    modport slave (
        input  m_stb_i, m_we_i, m_adr_i, m_dat_i, wb_dat_i, wb_ack_i,
        output m_dat_o, m_ack_o, m_err_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               grant_o, stray_ack_o
    );

    modport master (
        output m_stb_i, m_we_i, m_adr_i, m_dat_i, wb_dat_i, wb_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               grant_o, stray_ack_o
    );
endinterface

// File: rtl/wb_axi_bridge_arbiter.sv
// Round-robin arbiter sharing one Wishbone-to-AXI4-Lite bridge port among several masters,
// one transaction in flight, with an optional per-grant timeout that returns an error.
module wb_axi_bridge_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_axi_bridge_arbiter_if.slave bus
);
    localparam int unsigned   IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned   CW       = IW + 1;
    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
    } req_t;

    state_t                 state_q, state_d;
    req_t                   req_q, req_d, sel_req;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, sel_grant, ack_c, err_c;
    logic [IW-1:0]          gidx_q, gidx_d, ptr_q, ptr_d, win_idx;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic                   stb_q, stb_d, stray_q, stray_d;
    logic                   timeout_hit, found;
    logic [CW-1:0]          cand;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // First requester at or after the round-robin pointer, wrapping at NUM_MASTERS.
    always_comb begin
        win_idx = ptr_q;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_MASTERS)) begin
                cand = cand - CW'(NUM_MASTERS);
            end
            if (!found && bus.m_stb_i[cand[IW-1:0]]) begin
                win_idx = cand[IW-1:0];
                found   = 1'b1;
            end
        end
    end

    // Winner's request payload and one-hot grant.
    always_comb begin
        sel_req   = '0;
        sel_grant = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == IW'(i)) begin
                sel_grant[i] = 1'b1;
                sel_req.we   = bus.m_we_i[i];
                sel_req.adr  = bus.m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_req.dat  = bus.m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            stray_q <= stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        stray_d = stray_q | (bus.wb_ack_i && (state_q != ST_BUSY));
        ack_c   = '0;
        err_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    req_d   = sel_req;
                    grant_d = sel_grant;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack takes precedence over a timeout landing in the same cycle.
                if (bus.wb_ack_i || timeout_hit) begin
                    if (bus.wb_ack_i) begin
                        ack_c = grant_q;
                    end else begin
                        err_c = grant_q;
                    end
                    stb_d   = 1'b0;
                    grant_d = '0;
                    ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_we_o     = req_q.we;
    assign bus.wb_adr_o    = req_q.adr;
    assign bus.wb_dat_o    = req_q.dat;
    assign bus.m_ack_o     = ack_c;
    assign bus.m_err_o     = err_c;
    assign bus.m_dat_o     = bus.wb_dat_i;
    assign bus.grant_o     = grant_q;
    assign bus.stray_ack_o = stray_q;

endmodule

// File: tb/tb_wb_axi_bridge_arbiter.sv
// Directed bench for wb_axi_bridge_arbiter: table of single transactions plus
// hand-written stray-ack, strobe-drop and async-reset sequences.
module tb_wb_axi_bridge_arbiter;
    localparam int unsigned NM = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned NV = 14;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] adr;
        logic [31:0] dat;
        int unsigned ack_dly;   // idle BUSY cycles before the bridge acks; >= TO means never
        logic [31:0] rdata;
        logic [3:0]  exp_grant;
        logic        exp_we;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_ack;   // 1: ack expected, 0: timeout error expected
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    vec_t vec [NV];

    wb_axi_bridge_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_axi_bridge_arbiter #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Master i drives adr + 0x10*i and dat + i so the selected master is visible on the bus.
    task automatic drive(input logic [3:0] req, input logic [3:0] we,
                         input logic [31:0] adr, input logic [31:0] dat);
        bus.m_stb_i = req;
        bus.m_we_i  = we;
        for (int i = 0; i < NM; i++) begin
            bus.m_adr_i[i*AW +: AW] = adr + 32'(i) * 32'h10;
            bus.m_dat_i[i*DW +: DW] = dat + 32'(i);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  spurious;
        bit  done;
        string tag;
        tag = $sformatf("v%0d", idx);
        spurious = 0;
        done = 1'b0;
        @(negedge clk);
        drive(v.req, v.we, v.adr, v.dat);
        #1;
        chk({tag, " idle_stb"}, 64'(bus.wb_stb_o), 64'(1'b0));
        @(negedge clk);
        #1;
        chk({tag, " busy_stb"}, 64'(bus.wb_stb_o), 64'(1'b1));
        chk({tag, " grant"}, 64'(bus.grant_o), 64'(v.exp_grant));
        chk({tag, " we"}, 64'(bus.wb_we_o), 64'(v.exp_we));
        chk({tag, " adr"}, 64'(bus.wb_adr_o), 64'(v.exp_adr));
        chk({tag, " wdat"}, 64'(bus.wb_dat_o), 64'(v.exp_dat));
        // Masters change their payload mid-transaction; the bridge side must not follow.
        bus.m_we_i = ~v.we;
        for (int i = 0; i < NM; i++) begin
            bus.m_adr_i[i*AW +: AW] = ~bus.m_adr_i[i*AW +: AW];
            bus.m_dat_i[i*DW +: DW] = ~bus.m_dat_i[i*DW +: DW];
        end
        for (int c = 1; c <= int'(TO) && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (c == int'(v.ack_dly) + 1) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = v.rdata;
            end
            #1;
            if (bus.wb_ack_i) begin
                chk({tag, " ack"}, 64'(bus.m_ack_o), 64'(v.exp_ack ? v.exp_grant : 4'b0000));
                chk({tag, " err_on_ack"}, 64'(bus.m_err_o), 64'(4'b0000));
                chk({tag, " rdat"}, 64'(bus.m_dat_o), 64'(v.rdata));
                done = 1'b1;
            end else if (c == int'(TO)) begin
                chk({tag, " err"}, 64'(bus.m_err_o), 64'(v.exp_ack ? 4'b0000 : v.exp_grant));
                chk({tag, " ack_on_err"}, 64'(bus.m_ack_o), 64'(4'b0000));
                done = 1'b1;
            end else if (bus.m_ack_o != 4'b0000 || bus.m_err_o != 4'b0000) begin
                spurious++;
            end
        end
        chk({tag, " held_adr"}, 64'(bus.wb_adr_o), 64'(v.exp_adr));
        chk({tag, " early_resp"}, 64'(spurious), 64'(0));
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.m_stb_i  = 4'b0000;
        #1;
        chk({tag, " rel_stb"}, 64'(bus.wb_stb_o), 64'(1'b0));
        chk({tag, " rel_grant"}, 64'(bus.grant_o), 64'(4'b0000));
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        //             req      we       adr           dat           dly rdata         grant    we    exp_adr       exp_dat       ack
        vec[0]  = '{4'b0001, 4'b1111, 32'h0000_1000, 32'hDEAD_BEEF, 3,  32'h0000_0000, 4'b0001, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1};
        vec[1]  = '{4'b0100, 4'b0000, 32'h0000_1FE4, 32'h0000_0000, 1,  32'hCAFE_F00D, 4'b0100, 1'b0, 32'h0000_2004, 32'h0000_0002, 1'b1};
        vec[2]  = '{4'b1000, 4'b1000, 32'h0000_4000, 32'h55AA_0000, 2,  32'h1111_1111, 4'b1000, 1'b1, 32'h0000_4030, 32'h55AA_0003, 1'b1};
        vec[3]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 0,  32'h0000_00A0, 4'b0001, 1'b0, 32'h0000_3000, 32'h0000_0100, 1'b1};
        vec[4]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 1,  32'h0000_00A1, 4'b0010, 1'b1, 32'h0000_3010, 32'h0000_0101, 1'b1};
        vec[5]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 0,  32'h0000_00A2, 4'b0100, 1'b0, 32'h0000_3020, 32'h0000_0102, 1'b1};
        vec[6]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 2,  32'h0000_00A3, 4'b1000, 1'b1, 32'h0000_3030, 32'h0000_0103, 1'b1};
        vec[7]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 0,  32'h0000_00A4, 4'b0001, 1'b0, 32'h0000_3000, 32'h0000_0100, 1'b1};
        vec[8]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 3,  32'h0000_00A5, 4'b0010, 1'b1, 32'h0000_3010, 32'h0000_0101, 1'b1};
        vec[9]  = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 0,  32'h0000_00A6, 4'b0100, 1'b0, 32'h0000_3020, 32'h0000_0102, 1'b1};
        vec[10] = '{4'b1111, 4'b1010, 32'h0000_3000, 32'h0000_0100, 1,  32'h0000_00A7, 4'b1000, 1'b1, 32'h0000_3030, 32'h0000_0103, 1'b1};
        vec[11] = '{4'b0010, 4'b0010, 32'h0000_5000, 32'h0000_0077, 99, 32'h0000_0000, 4'b0010, 1'b1, 32'h0000_5010, 32'h0000_0078, 1'b0};
        vec[12] = '{4'b0110, 4'b0000, 32'h0000_6000, 32'h0000_0000, 15, 32'h0BAD_F00D, 4'b0100, 1'b0, 32'h0000_6020, 32'h0000_0002, 1'b1};
        vec[13] = '{4'b0011, 4'b0001, 32'h0000_7000, 32'h0000_0009, 0,  32'h7777_7777, 4'b0001, 1'b1, 32'h0000_7000, 32'h0000_0009, 1'b1};

        rst_n        = 1'b0;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        drive(4'b0000, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("rst stb", 64'(bus.wb_stb_o), 64'(1'b0));
        chk("rst grant", 64'(bus.grant_o), 64'(4'b0000));
        chk("rst adr", 64'(bus.wb_adr_o), 64'(32'h0));
        chk("rst ack_err", 64'({bus.m_ack_o, bus.m_err_o}), 64'(8'h00));
        chk("rst stray", 64'(bus.stray_ack_o), 64'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            run_vec(i, vec[i]);
        end

        // Ack from the bridge while idle is dropped but remembered.
        @(negedge clk);
        #1;
        chk("stray pre", 64'(bus.stray_ack_o), 64'(1'b0));
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h5555_AAAA;
        #1;
        chk("stray no_ack", 64'(bus.m_ack_o), 64'(4'b0000));
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        #1;
        chk("stray set", 64'(bus.stray_ack_o), 64'(1'b1));
        chk("stray no_stb", 64'(bus.wb_stb_o), 64'(1'b0));
        repeat (3) @(negedge clk);
        #1;
        chk("stray held", 64'(bus.stray_ack_o), 64'(1'b1));

        // Granted master withdraws its strobe; the transaction still completes.
        @(negedge clk);
        drive(4'b0001, 4'b0001, 32'h0000_8000, 32'h0000_1234);
        @(negedge clk);
        #1;
        chk("drop grant", 64'(bus.grant_o), 64'(4'b0001));
        bus.m_stb_i = 4'b0000;
        @(negedge clk);
        #1;
        chk("drop stb_held", 64'(bus.wb_stb_o), 64'(1'b1));
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h0000_4321;
        #1;
        chk("drop ack", 64'(bus.m_ack_o), 64'(4'b0001));
        @(negedge clk);
        bus.wb_ack_i = 1'b0;

        // Asynchronous reset while m1 holds the grant and the bridge is acking.
        @(negedge clk);
        drive(4'b0010, 4'b0000, 32'h0000_9000, 32'h0);
        @(negedge clk);
        #1;
        chk("arst grant", 64'(bus.grant_o), 64'(4'b0010));
        bus.wb_ack_i = 1'b1;
        #1;
        chk("arst ack_pre", 64'(bus.m_ack_o), 64'(4'b0010));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst stb", 64'(bus.wb_stb_o), 64'(1'b0));
        chk("arst grant0", 64'(bus.grant_o), 64'(4'b0000));
        chk("arst ack0", 64'(bus.m_ack_o), 64'(4'b0000));
        chk("arst stray0", 64'(bus.stray_ack_o), 64'(1'b0));
        bus.wb_ack_i = 1'b0;
        drive(4'b0011, 4'b0000, 32'h0000_A000, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst grant", 64'(bus.grant_o), 64'(4'b0001));
        chk("post_rst adr", 64'(bus.wb_adr_o), 64'(32'h0000_A000));
        bus.wb_ack_i = 1'b1;
        #1;
        chk("post_rst ack", 64'(bus.m_ack_o), 64'(4'b0001));
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.m_stb_i  = 4'b0000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
